fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Downstream consumer of the 8-bit byte FIFO; drains it and serialises each byte onto a UART TX line in 8N1 format, LSB first.
- FIFO interface is show-ahead: data is valid whenever empty is low, and a one-cycle read enable pops the word at the next clock edge.
- Sits between the FIFO and the board TX pin, so the FIFO absorbs producer bursts while this block paces output at the baud rate.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Must be at least 2. The baud counter width is $clog2(CLKS_PER_BIT).
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd. Used only when UART_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high; the top level derives it for this block.
- fifo_empty  input  1  FIFO empty flag; fifo_data is valid when this is low.
- fifo_data  input  8  show-ahead FIFO head word.
- fifo_rd_en  output  1  registered one-cycle pop request to the FIFO.
- tx  output  1  serial line; idles high.
- busy  output  1  high whenever state is not IDLE.
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Reset, asynchronous on rst high:
  - state = IDLE, tx = 1, busy = 0, fifo_rd_en = 0, tx_done = 0.
  - Baud counter, bit index and shift register are cleared.
  - Reset mid-frame: tx goes high immediately; the partial byte is discarded and not re-read.
- State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs are registered.
- IDLE:
  - tx = 1.
  - On an edge E0 with fifo_empty = 0: load fifo_data into the shift register, set fifo_rd_en <= 1, go to START.
  - With fifo_empty = 1: remain in IDLE.
- fifo_rd_en:
  - High for exactly the one cycle after E0, so the FIFO pops at E0+1.
  - Never asserted in any other cycle, so it can never pop an empty FIFO.
  - fifo_data is ignored outside IDLE.
- START: tx = 0 for CLKS_PER_BIT cycles, starting the cycle after E0.
- DATA:
  - 8 bits, each held for CLKS_PER_BIT cycles, shift_reg[0] first.
  - Shift right at the end of each bit; bit index counts 0..7.
- STOP:
  - tx = 1 for CLKS_PER_BIT cycles.
  - On the final cycle's edge: tx_done <= 1 for one cycle, state -> IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - Reset to 0 on entry to START.
- Frame timing:
  - Frame length is 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
  - At least one IDLE cycle separates frames, so back-to-back frame starts are 10*CLKS_PER_BIT+1 cycles apart.
- busy: rises the cycle after E0; falls in the same cycle tx_done is high.
- Boundary cases:
  - FIFO goes empty mid-frame: no effect on the current frame.
  - fifo_empty toggling while the block is not in IDLE: ignored.

Optional Feature:
- Macro: UART_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = (^byte) ^ PARITY_ODD for CLKS_PER_BIT cycles, computed from the byte as loaded.
  - Frame length is 11*CLKS_PER_BIT.
- Undefined: no parity state or logic; 8N1 only; PARITY_ODD is unused.

Test Plan:
1. Reset with CLKS_PER_BIT = 4 and fifo_empty = 1 -> tx = 1, busy = 0, fifo_rd_en = 0, tx_done = 0; no activity for 100 cycles.
2. Single byte 0xA5 presented with fifo_empty = 0 for one pop -> fifo_rd_en high for exactly 1 cycle; tx carries 0, then 1,0,1,0,0,1,0,1, then 1, each bit 4 cycles wide; tx_done pulses once 40 cycles after tx falls.
3. Three bytes 0x00, 0xFF, 0x55 queued -> exactly 3 fifo_rd_en pulses; frame starts 41 cycles apart; decoded bytes match in order.
4. rst pulsed high in the 3rd DATA bit of 0x3C -> tx = 1 asynchronously; state IDLE; the next queued byte 0x81 is sent intact after release; 0x3C is not resent.
5. fifo_empty toggled randomly during a frame of 0x5A -> no extra fifo_rd_en; the frame is unaffected.
6. With UART_PARITY_EN defined: 0x07 with PARITY_ODD = 0 -> parity bit 1; 0x03 with PARITY_ODD = 1 -> parity bit 1; frame is 44 cycles (CLKS_PER_BIT = 4).

Source files
------------

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead 8-bit byte FIFO and serialises each byte
// onto a UART TX line, 8N1, LSB first. Each frame is paced at CLKS_PER_BIT
// clocks per bit, and at least one idle cycle separates frames.
//
// Optional feature: define UART_PARITY_EN to insert a parity bit between the
// data bits and the stop bit. PARITY_ODD = 0 selects even parity and
// PARITY_ODD = 1 selects odd parity.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   fifo_empty FIFO empty flag; fifo_data is valid while low
//   fifo_data  show-ahead FIFO head word
//   fifo_rd_en registered one-cycle pop request
//   tx         serial line, idles high
//   busy       high whenever a frame is in progress
//   tx_done    one-cycle pulse when a stop bit completes
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_rd_en,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    localparam int unsigned     CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    // Reject parameter values the datapath cannot honour.
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
        end
        if (PARITY_ODD > 1) begin : g_bad_parity
            $error("fifo_uart_tx: PARITY_ODD must be 0 or 1");
        end
    endgenerate

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             tx_nxt, busy_nxt, rd_en_nxt, done_nxt;
    logic             bit_end;
`ifdef UART_PARITY_EN
    logic             par_q, par_nxt;
`endif

    assign bit_end = (cnt == CNT_MAX);

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            shift_reg  <= shift_nxt;
            tx         <= tx_nxt;
            busy       <= busy_nxt;
            fifo_rd_en <= rd_en_nxt;
            tx_done    <= done_nxt;
`ifdef UART_PARITY_EN
            par_q      <= par_nxt;
`endif
        end
    end

    // Next-state and next-output logic; tx_nxt is the level for the coming cycle.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift_reg;
        tx_nxt    = tx;
        busy_nxt  = busy;
        rd_en_nxt = 1'b0;
        done_nxt  = 1'b0;
`ifdef UART_PARITY_EN
        par_nxt   = par_q;
`endif

        // Baud counter free-runs inside a frame and wraps on each bit boundary.
        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                if (!fifo_empty) begin
                    // Head word is captured now; the pop lands one edge later.
                    shift_nxt = fifo_data;
                    rd_en_nxt = 1'b1;
                    cnt_nxt   = '0;
                    tx_nxt    = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = START;
`ifdef UART_PARITY_EN
                    par_nxt   = (^fifo_data) ^ 1'(PARITY_ODD);
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    bit_nxt   = '0;
                    tx_nxt    = shift_reg[0];
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                        tx_nxt    = par_q;
                        state_nxt = PARITY;
`else
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                        tx_nxt  = shift_reg[1];
                    end
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nxt    = 1'b1;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: directed self-checking bench for fifo_uart_tx with
// CLKS_PER_BIT = 4. Also builds with UART_PARITY_EN defined.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int P_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int errors = 0;
    int checks = 0;
    int rd_count = 0;
    bit noise = 1'b0;
    logic [7:0] q[$];

    logic tx_log   [0:63];
    logic done_log [0:63];
    logic busy_log [0:63];
    logic rd_log   [0:63];

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (P_ODD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // Show-ahead FIFO model driving the DUT inputs.
    function automatic void refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = (q.size() != 0) ? q[0] : 8'h00;
    endfunction

    // Advance one clock. A pop request seen before the edge pops at that edge.
    // Samples are taken 2 time units after the edge.
    task automatic step();
        if (fifo_rd_en === 1'b1) begin
            rd_count++;
            if (q.size() != 0) void'(q.pop_front());
        end
        @(posedge clk);
        #2;
        refresh();
        if (noise) begin
            fifo_empty = 1'($urandom_range(0, 1));
            fifo_data  = 8'($urandom);
        end
    endtask

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        refresh();
    endtask

    task automatic wait_fall(input int max, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < max) begin
            step();
            waited++;
        end
    endtask

    task automatic record(input int from, input int to);
        for (int i = from; i < to; i++) begin
            tx_log[i]   = tx;
            done_log[i] = tx_done;
            busy_log[i] = busy;
            rd_log[i]   = fifo_rd_en;
            step();
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[3'(b - 1)];
`ifdef UART_PARITY_EN
        if (b == 9) return (^d) ^ 1'(P_ODD);
`endif
        return 1'b1;
    endfunction

    function automatic int wave_errs(input logic [7:0] d);
        int n = 0;
        for (int c = 0; c < FRAME; c++)
            if (tx_log[c] !== frame_bit(d, c / CPB)) n++;
        return n;
    endfunction

    function automatic logic [7:0] decode();
        logic [7:0] r = 8'h00;
        for (int b = 0; b < 8; b++) r[3'(b)] = tx_log[(b + 1) * CPB + CPB / 2];
        return r;
    endfunction

    function automatic int done_count();
        int n = 0;
        for (int c = 0; c <= FRAME; c++)
            if (done_log[c] === 1'b1) n++;
        return n;
    endfunction

    task automatic test_reset();
        int act = 0;
        step(); step(); step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0 || tx_done !== 1'b0) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("FAIL idle_activity got=%0d exp=0", act); end
    endtask

    task automatic test_single();
        int w;
        int base = rd_count;
        push(8'hA5);
        wait_fall(10, w);
        checks++; if (w !== 1) begin errors++; $display("FAIL single_start_latency got=%0d exp=1", w); end
        record(0, FRAME + 1);
        checks++; if (wave_errs(8'hA5) !== 0) begin errors++; $display("FAIL single_wave bad_cycles=%0d exp=0", wave_errs(8'hA5)); end
        checks++; if (decode() !== 8'hA5) begin errors++; $display("FAIL single_byte got=%h exp=a5", decode()); end
        checks++; if (done_log[FRAME] !== 1'b1) begin errors++; $display("FAIL single_done_pos got=%b exp=1", done_log[FRAME]); end
        checks++; if (done_count() !== 1) begin errors++; $display("FAIL single_done_count got=%0d exp=1", done_count()); end
        checks++; if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL single_busy_rise got=%b exp=1", busy_log[0]); end
        checks++; if (busy_log[FRAME] !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%b exp=0", busy_log[FRAME]); end
        checks++; if (rd_log[0] !== 1'b1 || rd_log[1] !== 1'b0) begin errors++; $display("FAIL single_rd_pulse got=%b%b exp=10", rd_log[0], rd_log[1]); end
        checks++; if (rd_count - base !== 1) begin errors++; $display("FAIL single_rd_count got=%0d exp=1", rd_count - base); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'h55};
        int w;
        int base = rd_count;
        push(8'h00); push(8'hFF); push(8'h55);
        wait_fall(10, w);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_start got=%b exp=0", tx); end
        for (int k = 0; k < 3; k++) begin
            record(0, FRAME + 1);
            checks++; if (wave_errs(exp[k]) !== 0) begin errors++; $display("FAIL b2b_wave%0d bad_cycles=%0d exp=0", k, wave_errs(exp[k])); end
            checks++; if (decode() !== exp[k]) begin errors++; $display("FAIL b2b_byte%0d got=%h exp=%h", k, decode(), exp[k]); end
            checks++; if (done_log[FRAME] !== 1'b1 || tx_log[FRAME] !== 1'b1) begin errors++; $display("FAIL b2b_gap%0d done=%b tx=%b exp=1,1", k, done_log[FRAME], tx_log[FRAME]); end
            if (k < 2) begin
                checks++; if (tx !== 1'b0) begin errors++; $display("FAIL b2b_spacing%0d tx=%b exp=0 at 41 cycles", k, tx); end
            end
        end
        for (int i = 0; i < 20; i++) step();
        checks++; if (rd_count - base !== 3) begin errors++; $display("FAIL b2b_rd_count got=%0d exp=3", rd_count - base); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_idle_tx got=%b exp=1", tx); end
    endtask

    task automatic test_reset_mid_frame();
        int w;
        int base = rd_count;
        int falls = 0;
        push(8'h3C); push(8'h81);
        wait_fall(10, w);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_start got=%b exp=0", tx); end
        for (int i = 0; i < 13; i++) step();
        #1 rst = 1'b1;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx got=%b exp=1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got=%b exp=0", busy); end
        step(); step();
        rst = 1'b0;
        wait_fall(10, w);
        checks++; if (w !== 1) begin errors++; $display("FAIL mid_restart_latency got=%0d exp=1", w); end
        record(0, FRAME + 1);
        checks++; if (wave_errs(8'h81) !== 0) begin errors++; $display("FAIL mid_wave bad_cycles=%0d exp=0", wave_errs(8'h81)); end
        checks++; if (decode() !== 8'h81) begin errors++; $display("FAIL mid_byte got=%h exp=81", decode()); end
        for (int i = 0; i < 30; i++) begin
            step();
            if (tx !== 1'b1) falls++;
        end
        checks++; if (falls !== 0) begin errors++; $display("FAIL mid_no_resend got=%0d low cycles exp=0", falls); end
        checks++; if (rd_count - base !== 2) begin errors++; $display("FAIL mid_rd_count got=%0d exp=2", rd_count - base); end
    endtask

    task automatic test_empty_noise();
        int w;
        int base = rd_count;
        push(8'h5A);
        wait_fall(10, w);
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL noise_start got=%b exp=0", tx); end
        noise = 1'b1;
        record(0, FRAME - 1);
        noise = 1'b0;
        refresh();
        record(FRAME - 1, FRAME + 1);
        checks++; if (wave_errs(8'h5A) !== 0) begin errors++; $display("FAIL noise_wave bad_cycles=%0d exp=0", wave_errs(8'h5A)); end
        checks++; if (decode() !== 8'h5A) begin errors++; $display("FAIL noise_byte got=%h exp=5a", decode()); end
        checks++; if (done_count() !== 1) begin errors++; $display("FAIL noise_done_count got=%0d exp=1", done_count()); end
        for (int i = 0; i < 10; i++) step();
        checks++; if (rd_count - base !== 1) begin errors++; $display("FAIL noise_rd_count got=%0d exp=1", rd_count - base); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL noise_idle_tx got=%b exp=1", tx); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        int w;
        push(8'h07);
        wait_fall(10, w);
        record(0, FRAME + 1);
        checks++; if (tx_log[9 * CPB + 2] !== 1'b1) begin errors++; $display("FAIL parity_07 got=%b exp=1", tx_log[9 * CPB + 2]); end
        checks++; if (done_log[44] !== 1'b1) begin errors++; $display("FAIL parity_frame_len done@44=%b exp=1", done_log[44]); end
        checks++; if (wave_errs(8'h07) !== 0) begin errors++; $display("FAIL parity_wave bad_cycles=%0d exp=0", wave_errs(8'h07)); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_frame();
        test_empty_noise();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
